ycbcr_color_classifier: RTL

//  Pipelined, parametrised successor of the single-colour (green) pixel detector.

---
 rtl/ycbcr_color_classifier.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/ycbcr_color_classifier.sv
// ycbcr_color_classifier
// Three-stage YCbCr pixel classifier. Stage 1 captures the pixel and removes
// the chroma offset, stage 2 converts to saturated RGB, and stage 3 tests all
// six components against each class window. The block also keeps saturating
// per-frame hit counters that are reported on every frame_start pulse.
module ycbcr_color_classifier #(
  parameter int NUM_CLASSES = 4,
  parameter int CLS_W       = 2,
  parameter int CNT_W       = 20
) (
  input  logic                         PCLK,
  input  logic                         rst_n,
  input  logic                         e_pix,
  input  logic [7:0]                   Y,
  input  logic [7:0]                   Cb,
  input  logic [7:0]                   Cr,
  input  logic                         frame_start,
  input  logic                         cfg_we,
  input  logic [CLS_W-1:0]             cfg_class,
  input  logic [2:0]                   cfg_field,
  input  logic [7:0]                   cfg_min,
  input  logic [7:0]                   cfg_max,
  output logic                         out_valid,
  output logic [NUM_CLASSES-1:0]       class_hit,
  output logic                         class_any,
  output logic [CLS_W-1:0]             class_id,
  output logic [7:0]                   R_out,
  output logic [7:0]                   G_out,
  output logic [7:0]                   B_out,
  output logic [7:0]                   Y_dec,
  output logic                         count_valid,
  output logic [NUM_CLASSES*CNT_W-1:0] count_data
);

  localparam int NUM_FIELDS = 6;  // Y, Cb, Cr, R, G, B

  // Window configuration.
  logic [7:0]             win_min [NUM_CLASSES][NUM_FIELDS];
  logic [7:0]             win_max [NUM_CLASSES][NUM_FIELDS];
  logic [NUM_CLASSES-1:0] cls_en;

  // Stage 1.
  logic              v1;
  logic [7:0]        y1;
  logic signed [8:0] cb1, cr1;

  // Stage 2.
  logic              v2;
  logic [7:0]        y2, cb2, cr2, r2, g2, b2;
  logic signed [19:0] cb_x, cr_x, r_full, g_full, b_full;

  // Stage 3 combinational match.
  logic [7:0]             fv [NUM_FIELDS];
  logic [NUM_CLASSES-1:0] hit_nxt;
  logic [CLS_W-1:0]       id_nxt;

  // Counters.
  logic [CNT_W-1:0] cnt     [NUM_CLASSES];
  logic [CNT_W-1:0] cnt_nxt [NUM_CLASSES];

  // Clamp a wide signed colour value into the 0..255 range.
  function automatic logic [7:0] clamp8(input logic signed [19:0] v);
    if (v < 0)
      return 8'd0;
    else if (v > 20'sd255)
      return 8'd255;
    else
      return v[7:0];
  endfunction

  // Configuration registers: one window or enable bit per write strobe.
  // NOTE: the window table is reset like any other flop because its
  // default (full range, class disabled) is visible behaviour, not don't-care.
  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      cls_en <= '0;
      for (int k = 0; k < NUM_CLASSES; k++) begin
        for (int f = 0; f < NUM_FIELDS; f++) begin
          win_min[k][f] <= 8'd0;
          win_max[k][f] <= 8'd255;
        end
      end
    end else if (cfg_we && (32'(cfg_class) < NUM_CLASSES)) begin
      case (cfg_field)
        3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5: begin
          win_min[cfg_class][cfg_field] <= cfg_min;
          win_max[cfg_class][cfg_field] <= cfg_max;
        end
        3'd6:    cls_en[cfg_class] <= cfg_min[0];
        default: ;  // field 7 has no register behind it
      endcase
    end
  end

  // Stage 1: capture luma and convert chroma to signed offsets.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's value from before the edge.
  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      y1  <= 8'd0;
      cb1 <= 9'sd0;
      cr1 <= 9'sd0;
    end else begin
      v1  <= e_pix;
      y1  <= Y;
      cb1 <= $signed({1'b0, Cb}) - 9'sd128;
      cr1 <= $signed({1'b0, Cr}) - 9'sd128;
    end
  end

  // Stage 2 arithmetic: fixed-point colour matrix with floor shifts.
  always_comb begin
    cb_x   = $signed({{11{cb1[8]}}, cb1});
    cr_x   = $signed({{11{cr1[8]}}, cr1});
    r_full = $signed({12'd0, y1}) + ((20'sd1436 * cr_x) >>> 10);
    g_full = $signed({12'd0, y1}) - ((20'sd352 * cb_x) >>> 10)
                                  - ((20'sd730 * cr_x) >>> 10);
    b_full = $signed({12'd0, y1}) + ((20'sd1815 * cb_x) >>> 10);
  end

  // Stage 2 registers: saturated RGB plus the raw YCbCr for window tests.
  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      v2  <= 1'b0;
      y2  <= 8'd0;
      cb2 <= 8'd0;
      cr2 <= 8'd0;
      r2  <= 8'd0;
      g2  <= 8'd0;
      b2  <= 8'd0;
    end else begin
      v2  <= v1;
      y2  <= y1;
      cb2 <= {~cb1[7], cb1[6:0]};  // undo the -128 offset
      cr2 <= {~cr1[7], cr1[6:0]};
      r2  <= clamp8(r_full);
      g2  <= clamp8(g_full);
      b2  <= clamp8(b_full);
    end
  end

  // Stage 3 match: inclusive window test on all fields, lowest index wins.
  // NOTE: every output of this block gets a default first so no latch forms.
  always_comb begin
    fv[0]   = y2;
    fv[1]   = cb2;
    fv[2]   = cr2;
    fv[3]   = r2;
    fv[4]   = g2;
    fv[5]   = b2;
    hit_nxt = cls_en;
    id_nxt  = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      for (int f = 0; f < NUM_FIELDS; f++) begin
        if (fv[f] < win_min[k][f] || fv[f] > win_max[k][f])
          hit_nxt[k] = 1'b0;
      end
    end
    for (int k = NUM_CLASSES - 1; k >= 0; k--) begin
      if (hit_nxt[k])
        id_nxt = CLS_W'(k);
    end
  end

  // Stage 3 registers: outputs update only for valid pixels and hold otherwise.
  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      class_hit <= '0;
      class_any <= 1'b0;
      class_id  <= '0;
      R_out     <= 8'd0;
      G_out     <= 8'd0;
      B_out     <= 8'd0;
      Y_dec     <= 8'd0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        class_hit <= hit_nxt;
        class_any <= |hit_nxt;
        class_id  <= id_nxt;
        R_out     <= r2;
        G_out     <= g2;
        B_out     <= b2;
        Y_dec     <= {(|hit_nxt) ? 2'b11 : 2'b00, y2[7:2]};
      end
    end
  end

  // Next counter value: add this cycle's hit, sticking at all-ones.
  always_comb begin
    for (int k = 0; k < NUM_CLASSES; k++) begin
      cnt_nxt[k] = cnt[k];
      if (out_valid && class_hit[k] && (cnt[k] != '1))
        cnt_nxt[k] = cnt[k] + CNT_W'(1);
    end
  end

  // Frame counters: a hit on the frame_start cycle closes out the old frame.
  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      count_valid <= 1'b0;
      count_data  <= '0;
      for (int k = 0; k < NUM_CLASSES; k++)
        cnt[k] <= '0;
    end else begin
      count_valid <= frame_start;
      for (int k = 0; k < NUM_CLASSES; k++) begin
        if (frame_start) begin
          count_data[k*CNT_W +: CNT_W] <= cnt_nxt[k];
          cnt[k]                       <= '0;
        end else begin
          cnt[k] <= cnt_nxt[k];
        end
      end
    end
  end

endmodule
